// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests under a
// credit limit, buffers returned words with their PCs and drops wrong-path responses after redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_f,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid_f,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pcplus4_f
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam int DISC_W = 8;

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DISC_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0]  pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

    logic [31:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0] fifo_instr_d [FIFO_DEPTH];
    logic [31:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0] fifo_pc_d    [FIFO_DEPTH];
    logic [31:0] pcq_pc_q     [FIFO_DEPTH];
    logic [31:0] pcq_pc_d     [FIFO_DEPTH];

    logic [SUM_W-1:0] credit_used;
    logic handshake, rsp_accept, rsp_discard, rsp_any, pop;

    // Outstanding requests plus buffered words never exceed the FIFO depth, so a
    // returning word always has a slot even when nothing is being popped.
    always_comb begin
        credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
        imem_req    = rst_n & ~redirect_valid & (credit_used < SUM_W'(FIFO_DEPTH));
        imem_addr   = fetch_pc_q;
        handshake   = imem_req & imem_gnt;
        rsp_discard = imem_rvalid & (discard_q != '0);
        rsp_accept  = imem_rvalid & (discard_q == '0) & (outstanding_q != '0);
        rsp_any     = rsp_discard | rsp_accept;
        valid_f     = (fifo_cnt_q != '0);
        pop         = valid_f & ~stall_f;
    end

    always_comb begin
        instr_f   = 32'h0000_0000;
        pc_f      = 32'hFFFF_FFFF;
        pcplus4_f = 32'hFFFF_FFFF;
        if (valid_f) begin
            instr_f   = fifo_instr_q[fifo_rd_q];
            pc_f      = fifo_pc_q[fifo_rd_q];
            pcplus4_f = fifo_pc_q[fifo_rd_q] + 32'd4;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        fifo_cnt_d    = fifo_cnt_q;
        discard_d     = discard_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        pcq_pc_d      = pcq_pc_q;

        if (redirect_valid) begin
            // Every request still in flight becomes a response to throw away;
            // one arriving this very cycle is already accounted for.
            fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
            discard_d     = discard_q + DISC_W'(outstanding_q) - DISC_W'(rsp_any);
            outstanding_d = '0;
            fifo_cnt_d    = '0;
            fifo_wr_d     = '0;
            fifo_rd_d     = '0;
            pcq_wr_d      = '0;
            pcq_rd_d      = '0;
        end else begin
            if (handshake) begin
                pcq_pc_d[pcq_wr_q] = fetch_pc_q;
                pcq_wr_d           = pcq_wr_q + PTR_W'(1);
                fetch_pc_d         = fetch_pc_q + 32'd4;
            end
            if (rsp_discard) begin
                discard_d = discard_q - DISC_W'(1);
            end
            if (rsp_accept) begin
                fifo_instr_d[fifo_wr_q] = imem_rdata;
                fifo_pc_d[fifo_wr_q]    = pcq_pc_q[pcq_rd_q];
                fifo_wr_d               = fifo_wr_q + PTR_W'(1);
                pcq_rd_d                = pcq_rd_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + PTR_W'(1);
            end
            outstanding_d = outstanding_q + CNT_W'(handshake) - CNT_W'(rsp_accept);
            fifo_cnt_d    = fifo_cnt_q + CNT_W'(rsp_accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            discard_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            discard_q     <= discard_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
        end
    end

    // Storage slots carry no reset: their contents only matter while the counts say so.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                fifo_instr_q[gi] <= fifo_instr_d[gi];
                fifo_pc_q[gi]    <= fifo_pc_d[gi];
                pcq_pc_q[gi]     <= pcq_pc_d[gi];
            end
        end
    endgenerate

    stray_rvalid_a: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outstanding_q != '0 || discard_q != '0));

endmodule
